control_muestreo_adc: RTL and testbench
=======================================

# control_muestreo_adc

Sampling controller for the serial 12-bit ADC feeding the equalizer filter chain. It generates the audio sample-rate tick, drives the ADC chip-select and serial clock, and shifts in one 16-bit frame per sample. It presents the 12-bit result on `data_ADC` with a one-cycle `listo` strobe. `data_ADC` goes to the ADC concatenation/offset-removal stage ahead of the filters, and `listo` acts as the filter-bank sample-enable.

## Interface
- `N_ADC`, 12: ADC result width; frame is always 16 bits (4 leading zeros + N_ADC data, MSB first)
- `DIV_SCLK`, 2: clk cycles per SCLK half-period (≥1)
- `CICLOS_MUESTREO`, 2268: clk cycles per sample period (44.1 kHz at 100 MHz); must be ≥ 32·DIV_SCLK + 4

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  1 = run sampling; 0 = stop after current frame
- `sdata`  in  1  ADC serial data, registered once inside block before use
- `sclk`  out  1  ADC serial clock, registered, idles high
- `cs_n`  out  1  ADC chip select, registered, active low
- `data_ADC`  out  N_ADC  last completed sample, held until next frame completes
- `listo`  out  1  one-cycle strobe: `data_ADC` updated this cycle
- `overrun`  out  1  sticky: sample tick occurred while a frame was in progress

## Operation
- Reset values: `sclk`=1, `cs_n`=1, `data_ADC`=0, `listo`=0, `overrun`=0, state IDLE, rate counter 0, shift register 0, bit counter 0.
- Rate counter counts 0..CICLOS_MUESTREO−1 and wraps. It runs only while `enable`=1 and is cleared to 0 when `enable`=0. `tick` is asserted internally in the cycle the counter equals CICLOS_MUESTREO−1.
- FSM states:
  - IDLE: `cs_n`=1, `sclk`=1. On `tick`, go to CONV next cycle.
  - CONV: `cs_n`=0. The half-period counter counts 0..DIV_SCLK−1. At each terminal count `sclk` toggles.
    - On a 1→0 toggle, no sample is taken.
    - On a 0→1 toggle, the registered `sdata` is shifted into the LSB of the 16-bit shift register and the bit counter increments.
    - When the bit counter reaches 16, go to FIN.
  - FIN (one cycle): `cs_n`=1, `sclk`=1, `data_ADC` ← shift[N_ADC−1:0], `listo`=1. Next state is IDLE.
- The 4 leading frame bits are discarded; they are not checked.
- `tick` in CONV or FIN sets `overrun`=1. The tick is ignored; the frame in progress is not restarted. `overrun` clears only on `reset`.
- `enable` falling during CONV: the frame completes normally, including `listo`. No new tick is generated after that.
- `reset` mid-frame: next cycle all outputs are at reset values. The partial frame is discarded and `data_ADC` is not updated.

## Timing
- First tick after reset release with `enable`=1: CICLOS_MUESTREO cycles after the first enabled cycle.
- `cs_n` falls 1 cycle after `tick`. The first `sclk` fall follows DIV_SCLK cycles later.
- A frame lasts 32·DIV_SCLK cycles with `cs_n` low. The 16th rising `sclk` sample occurs on the last of these cycles.
- `listo`/`data_ADC` update: 1 cycle after the 16th rise. Total latency from `tick` to `listo` is 32·DIV_SCLK + 1 cycles.
- `sdata` is sampled through one register stage. The value captured at a rising `sclk` edge is the `sdata` present 1 clk before that edge's toggle cycle. The ADC therefore has ≥ DIV_SCLK−1 cycles of setup after the `sclk` fall.
- `listo` period in steady state is exactly CICLOS_MUESTREO cycles.

## Test plan
Use DIV_SCLK=2, CICLOS_MUESTREO=100 unless stated.

- **Reset/idle:** hold `reset`=1 for 5 cycles, `enable`=1 → `sclk`=1, `cs_n`=1, `data_ADC`=0, `listo`=0, `overrun`=0 throughout reset. First `cs_n` fall occurs 100 cycles after reset release.
- **Single conversion:** an ADC model returns frame 0x0ABC MSB-first on `sclk` falls → `cs_n` low for 64 cycles, exactly 16 `sclk` rising edges, then `listo`=1 for one cycle with `data_ADC`=0xABC.
- **Extremes and leading bits:** frames 0x0FFF, 0x0000, then 0xF800 with leading ones → `data_ADC` = 0xFFF, 0x000, 0x800 respectively. Consecutive `listo` pulses are exactly 100 cycles apart.
- **Overrun:** CICLOS_MUESTREO=40 (violates the constraint) → `overrun` rises at the tick during the first CONV and stays 1. The first frame still completes with correct data and is not restarted.
- **Enable drop mid-frame:** deassert `enable` 10 cycles after `cs_n` falls → the frame completes with `listo`=1 and correct data. No further `cs_n` fall within 300 cycles.
- **Reset mid-frame:** assert `reset` 20 cycles into CONV → next cycle `cs_n`=1, `sclk`=1, `listo`=0, `data_ADC` keeps its reset value 0. Normal sampling resumes 100 cycles after release.

Source files
------------

// File: rtl/control_muestreo_adc.sv
// Sampling controller for a serial 12-bit ADC: generates the sample-rate tick, drives cs_n/sclk
// and shifts in one 16-bit MSB-first frame per sample, presenting the result with a listo strobe.
module control_muestreo_adc #(
  parameter int unsigned N_ADC           = 12,
  parameter int unsigned DIV_SCLK        = 2,
  parameter int unsigned CICLOS_MUESTREO = 2268
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sdata,
  output logic             sclk,
  output logic             cs_n,
  output logic [N_ADC-1:0] data_ADC,
  output logic             listo,
  output logic             overrun
);

  localparam int unsigned RateW = (CICLOS_MUESTREO > 1) ? $clog2(CICLOS_MUESTREO) : 1;
  localparam int unsigned HalfW = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
  localparam logic [RateW-1:0] RateLast = RateW'(CICLOS_MUESTREO - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(DIV_SCLK - 1);

  typedef enum logic [1:0] {StIdle, StConv, StFin} state_e;

  state_e           state_q;
  logic [RateW-1:0] rate_q;
  logic [HalfW-1:0] half_q;
  logic [4:0]       bits_q;
  logic [15:0]      shift_q;
  logic [15:0]      shift_next;
  logic             sdata_q;
  logic             tick;

  // Gating with enable keeps a stale terminal count from ticking once sampling stops.
  assign tick       = enable && (rate_q == RateLast);
  assign shift_next = (shift_q << 1) | {15'b0, sdata_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q  <= '0;
      sdata_q <= 1'b0;
    end else begin
      sdata_q <= sdata;
      if (!enable || rate_q == RateLast) begin
        rate_q <= '0;
      end else begin
        rate_q <= rate_q + RateW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sclk     <= 1'b1;
      cs_n     <= 1'b1;
      data_ADC <= '0;
      listo    <= 1'b0;
      overrun  <= 1'b0;
      half_q   <= '0;
      bits_q   <= '0;
      shift_q  <= '0;
    end else begin
      listo <= 1'b0;
      // A tick while busy is only flagged; the running frame is never restarted.
      if (tick && state_q != StIdle) begin
        overrun <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          cs_n   <= 1'b1;
          sclk   <= 1'b1;
          half_q <= '0;
          bits_q <= '0;
          if (tick) begin
            state_q <= StConv;
            cs_n    <= 1'b0;
          end
        end
        StConv: begin
          if (half_q == HalfLast) begin
            half_q <= '0;
            sclk   <= ~sclk;
            if (!sclk) begin
              shift_q <= shift_next;
              bits_q  <= bits_q + 5'd1;
              if (bits_q == 5'd15) begin
                state_q  <= StFin;
                cs_n     <= 1'b1;
                data_ADC <= N_ADC'(shift_next);
                listo    <= 1'b1;
              end
            end
          end else begin
            half_q <= half_q + HalfW'(1);
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_muestreo_adc.sv
// Directed bench for control_muestreo_adc: a behavioural ADC drives sdata MSB-first on sclk falls.
module tb_control_muestreo_adc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_ov = 1'b1;
  logic        enable = 1'b1;
  logic        sdata = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] frame = 16'h0000;
  int          idx = 0;
  int          cyc = 0;
  int          last_lc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        sclk, cs_n, listo, overrun;
  logic [11:0] data_adc;
  logic        sclk_ov, cs_n_ov, listo_ov, overrun_ov;
  logic [11:0] data_adc_ov;
  logic        m_sclk, m_cs, m_listo, m_ov;
  logic [11:0] m_data;

  control_muestreo_adc #(.N_ADC(12), .DIV_SCLK(2), .CICLOS_MUESTREO(100)) dut (
    .clk(clk), .reset(rst), .enable(enable), .sdata(sdata), .sclk(sclk), .cs_n(cs_n),
    .data_ADC(data_adc), .listo(listo), .overrun(overrun)
  );

  control_muestreo_adc #(.N_ADC(12), .DIV_SCLK(2), .CICLOS_MUESTREO(40)) dut_ov (
    .clk(clk), .reset(rst_ov), .enable(enable), .sdata(sdata), .sclk(sclk_ov), .cs_n(cs_n_ov),
    .data_ADC(data_adc_ov), .listo(listo_ov), .overrun(overrun_ov)
  );

  assign m_sclk  = sel ? sclk_ov : sclk;
  assign m_cs    = sel ? cs_n_ov : cs_n;
  assign m_listo = sel ? listo_ov : listo;
  assign m_ov    = sel ? overrun_ov : overrun;
  assign m_data  = sel ? data_adc_ov : data_adc;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: restart on cs_n fall, present the next frame bit on every sclk fall.
  always @(negedge m_cs or negedge m_sclk) begin
    if (m_sclk === 1'b1) begin
      idx = 0;
    end else begin
      if (idx < 16) sdata = frame[15 - idx];
      idx = idx + 1;
    end
  end

  task automatic wait_cs_fall(input int limit, output int n);
    n = 0;
    while (m_cs !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Starts on a sample with cs_n low; ends on the first sample with cs_n high (the FIN cycle).
  task automatic measure_frame(output int low, output int rises, output logic lst,
                               output logic [11:0] d, output int lc);
    logic prev;
    low   = 0;
    rises = 0;
    prev  = m_sclk;
    while (m_cs === 1'b0 && low < 200) begin
      low++;
      @(negedge clk);
      if (m_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = m_sclk;
    end
    lst = m_listo;
    d   = m_data;
    lc  = cyc;
  endtask

  task automatic test_reset();
    int n;
    rst    = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({sclk, cs_n, listo, overrun} !== 4'b1100 || data_adc !== 12'h000) begin
        failures++;
        $display("FAIL reset_outputs: got sclk=%b cs_n=%b listo=%b ovr=%b data=%h want 1 1 0 0 000",
                 sclk, cs_n, listo, overrun, data_adc);
      end
    end
    rst = 1'b0;
    wait_cs_fall(200, n);
    checks++;
    if (n !== 100) begin
      failures++;
      $display("FAIL first_cs_fall: got %0d cycles expected 100", n);
    end
  endtask

  task automatic test_single();
    int low, rises, lc;
    logic lst;
    logic [11:0] d;
    frame = 16'h0ABC;
    measure_frame(low, rises, lst, d, lc);
    last_lc = lc;
    checks++;
    if (low !== 64) begin
      failures++;
      $display("FAIL single_cs_low: got %0d expected 64", low);
    end
    checks++;
    if (rises !== 16) begin
      failures++;
      $display("FAIL single_rises: got %0d expected 16", rises);
    end
    checks++;
    if (lst !== 1'b1 || d !== 12'hABC) begin
      failures++;
      $display("FAIL single_data: got listo=%b data=%h expected 1 abc", lst, d);
    end
    @(negedge clk);
    checks++;
    if (listo !== 1'b0) begin
      failures++;
      $display("FAIL single_listo_pulse: got %b expected 0", listo);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] fr [3];
    logic [11:0] ex [3];
    int n, low, rises, lc;
    logic lst;
    logic [11:0] d;
    fr[0] = 16'h0FFF; fr[1] = 16'h0000; fr[2] = 16'hF800;
    ex[0] = 12'hFFF;  ex[1] = 12'h000;  ex[2] = 12'h800;
    for (int k = 0; k < 3; k++) begin
      wait_cs_fall(200, n);
      frame = fr[k];
      measure_frame(low, rises, lst, d, lc);
      checks++;
      if (lst !== 1'b1 || d !== ex[k]) begin
        failures++;
        $display("FAIL extreme_data[%0d]: got listo=%b data=%h expected 1 %h", k, lst, d, ex[k]);
      end
      checks++;
      if (lc - last_lc !== 100) begin
        failures++;
        $display("FAIL listo_period[%0d]: got %0d expected 100", k, lc - last_lc);
      end
      last_lc = lc;
    end
  endtask

  task automatic test_enable_drop();
    int n, low, rises, lc;
    logic lst;
    logic [11:0] d;
    wait_cs_fall(200, n);
    frame = 16'h0123;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    measure_frame(low, rises, lst, d, lc);
    checks++;
    if (lst !== 1'b1 || d !== 12'h123) begin
      failures++;
      $display("FAIL enable_drop_data: got listo=%b data=%h expected 1 123", lst, d);
    end
    wait_cs_fall(300, n);
    checks++;
    if (n !== 300) begin
      failures++;
      $display("FAIL enable_drop_idle: cs_n fell after %0d cycles expected none in 300", n);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, low, rises, lc;
    logic lst;
    logic [11:0] d;
    rst    = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    wait_cs_fall(200, n);
    checks++;
    if (n !== 100) begin
      failures++;
      $display("FAIL mid_first_fall: got %0d expected 100", n);
    end
    frame = 16'h0555;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cs_n, sclk, listo} !== 3'b110 || data_adc !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got cs_n=%b sclk=%b listo=%b data=%h expected 1 1 0 000",
               cs_n, sclk, listo, data_adc);
    end
    rst = 1'b0;
    wait_cs_fall(200, n);
    checks++;
    if (n !== 100) begin
      failures++;
      $display("FAIL mid_resume: got %0d expected 100", n);
    end
    measure_frame(low, rises, lst, d, lc);
    checks++;
    if (lst !== 1'b1 || d !== 12'h555) begin
      failures++;
      $display("FAIL mid_resume_data: got listo=%b data=%h expected 1 555", lst, d);
    end
  endtask

  task automatic test_overrun();
    int n, low, rises, lc;
    logic lst;
    logic [11:0] d;
    rst    = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    sel    = 1'b1;
    @(negedge clk);
    rst_ov = 1'b0;
    wait_cs_fall(200, n);
    checks++;
    if (n !== 40 || m_ov !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first_fall: got %0d cycles ovr=%b expected 40 0", n, m_ov);
    end
    frame = 16'h0A5A;
    measure_frame(low, rises, lst, d, lc);
    checks++;
    if (low !== 64 || rises !== 16) begin
      failures++;
      $display("FAIL ovr_no_restart: got low=%0d rises=%0d expected 64 16", low, rises);
    end
    checks++;
    if (lst !== 1'b1 || d !== 12'hA5A || m_ov !== 1'b1) begin
      failures++;
      $display("FAIL ovr_frame1: got listo=%b data=%h ovr=%b expected 1 a5a 1", lst, d, m_ov);
    end
    wait_cs_fall(200, n);
    frame = 16'h0321;
    measure_frame(low, rises, lst, d, lc);
    checks++;
    if (lst !== 1'b1 || d !== 12'h321 || m_ov !== 1'b1) begin
      failures++;
      $display("FAIL ovr_frame2: got listo=%b data=%h ovr=%b expected 1 321 1", lst, d, m_ov);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_enable_drop();
    test_reset_mid_frame();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
